// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   REG_AW      : default register address width
//   FWD_*       : EX operand source selects driven onto fwd_a / fwd_b
//   CD_W        : width of the MULT/DIV countdown (covers MULDIV_LAT up to 15)
//   md_state_t  : MULT/DIV sequencer states
//   fwd_pick()  : turns MEM/WB hit flags into a forwarding select
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int CD_W = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // The MEM-stage result is younger than the WB result, so it wins when both hit.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// IDLE/BUSY sequencer for the multi-cycle MULT/DIV unit.
//   clk          : pipeline clock, rising edge
//   rst          : asynchronous active-high reset
//   start_req    : a MULT/DIV in ID is allowed to issue this cycle
//   muldiv_start : one-cycle start pulse, asserted in the same cycle as the
//                  accepted request
//   muldiv_busy  : unit in progress; HI/LO is valid again once this drops
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  output logic muldiv_start,
  output logic muldiv_busy
);
  import mips_pkg::*;

  // Countdown runs LAT-1 .. 0 so BUSY lasts exactly MULDIV_LAT cycles.
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MULDIV_LAT - 1);

  md_state_t       state;
  logic [CD_W-1:0] countdown;

  // A request is only honoured from IDLE; while BUSY the top stalls the
  // requester instead. Reset masks the pulse so nothing issues while held.
  assign muldiv_start = !rst && (state == MD_IDLE) && start_req;
  assign muldiv_busy  = (state == MD_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      countdown <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (muldiv_start) begin
            state     <= MD_BUSY;
            countdown <= CD_LOAD;
          end
        end
        MD_BUSY: begin
          if (countdown == '0) begin
            state <= MD_IDLE;
          end else begin
            countdown <= countdown - CD_W'(1);
          end
        end
        default: begin
          state     <= MD_IDLE;
          countdown <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Central hazard controller for the 5-stage MIPS pipeline.
//   clk, rst                   : clock / asynchronous active-high reset
//   id_rs, id_rt, id_uses_*    : source registers of the instruction in ID
//   id_is_muldiv, id_reads_hilo: ID holds MULT/DIV or MFHI/MFLO
//   ex_rs, ex_rt, ex_rd        : registers of the instruction in EX
//   ex_reg_write, ex_mem_read  : EX writes a register / is a load
//   mem_rd, mem_reg_write      : MEM-stage destination
//   wb_rd, wb_reg_write        : WB-stage destination
//   ex_branch_taken            : branch/jump resolved taken in EX
//   stall_pc, stall_ifid       : hold PC and IF/ID
//   flush_ifid, bubble_idex    : squash IF/ID, insert NOP into ID/EX
//   fwd_a, fwd_b               : EX operand sources (mips_pkg FWD_*)
//   muldiv_start, muldiv_busy  : MULT/DIV sequencing
//   stall_cycles, flush_count  : wrapping performance counters
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_AW     = mips_pkg::REG_AW,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_muldiv,
  input  logic              id_reads_hilo,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_branch_taken,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              muldiv_start,
  output logic              muldiv_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  import mips_pkg::*;

  logic lu;
  logic md;
  logic branch;
  logic stall;
  logic start_req;

  // $0 is hardwired to zero, so a producer targeting it is never a hazard
  // and never a forwarding source.
  function automatic logic reg_hit(input logic [REG_AW-1:0] x,
                                   input logic [REG_AW-1:0] y);
    return (x == y) && (y != '0);
  endfunction

  // All hazard terms are masked by reset so every combinational output is 0
  // while rst is held, whatever the pipeline presents.
  always_comb begin
    lu     = 1'b0;
    md     = 1'b0;
    branch = 1'b0;
    if (!rst) begin
      lu = ex_mem_read && ex_reg_write &&
           ((id_uses_rs && reg_hit(id_rs, ex_rd)) ||
            (id_uses_rt && reg_hit(id_rt, ex_rd)));
      md     = muldiv_busy && (id_is_muldiv || id_reads_hilo);
      branch = ex_branch_taken;
    end
  end

  // A taken branch wins: the ID instruction is on the wrong path, so it is
  // flushed rather than held, and it must not launch a MULT/DIV.
  assign stall     = (lu || md) && !branch;
  assign start_req = id_is_muldiv && !lu && !branch;

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall || branch;
  assign flush_ifid  = branch;

  muldiv_seq #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_seq (
    .clk          (clk),
    .rst          (rst),
    .start_req    (start_req),
    .muldiv_start (muldiv_start),
    .muldiv_busy  (muldiv_busy)
  );

  // Forwarding selects are purely combinational so EX sees them in the same
  // cycle the operands are consumed.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_pick(mem_reg_write && reg_hit(ex_rs, mem_rd),
                       wb_reg_write  && reg_hit(ex_rs, wb_rd));
      fwd_b = fwd_pick(mem_reg_write && reg_hit(ex_rt, mem_rd),
                       wb_reg_write  && reg_hit(ex_rt, wb_rd));
    end
  end

  // Counters wrap naturally at 2^CNT_W; a cycle with both lu and md counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo;
  logic          ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic          ex_branch_taken;
  logic          stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]    fwd_a, fwd_b;
  logic          muldiv_start, muldiv_busy;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: remaining busy cycles of the MULT/DIV and counters.
  int            md_left = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       bubble;
    logic       start;
    logic       busy;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  hazard_stall_ctrl #(
    .REG_AW     (AW),
    .MULDIV_LAT (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_muldiv    (id_is_muldiv),
    .id_reads_hilo   (id_reads_hilo),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (stall_pc),
    .stall_ifid      (stall_ifid),
    .flush_ifid      (flush_ifid),
    .bubble_idex     (bubble_idex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .muldiv_start    (muldiv_start),
    .muldiv_busy     (muldiv_busy),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] src_for(input logic [AW-1:0] r);
    if (r == 0) return 2'd0;
    if (mem_reg_write && mem_rd == r) return 2'd1;
    if (wb_reg_write && wb_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    bit   lu, md;
    e = '0;
    if (rst) return e;
    lu = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    e.busy   = (md_left > 0);
    md       = e.busy && (id_is_muldiv || id_reads_hilo);
    e.flush  = ex_branch_taken;
    e.stall  = (lu || md) && !ex_branch_taken;
    e.bubble = e.stall || ex_branch_taken;
    e.start  = !e.busy && id_is_muldiv && !lu && !ex_branch_taken;
    e.fa     = src_for(ex_rs);
    e.fb     = src_for(ex_rt);
    return e;
  endfunction

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    exp_t e;
    e = model_now();
    @(posedge clk);
    if (!rst) begin
      if (e.stall) exp_stall = exp_stall + 1;
      if (ex_branch_taken) exp_flush = exp_flush + 1;
      if (e.start) md_left = LAT;
      else if (md_left > 0) md_left = md_left - 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_muldiv = 0; id_reads_hilo = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_branch_taken = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    md_left = 0; exp_stall = '0; exp_flush = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_rs = 1; id_rt = 1; id_uses_rs = 1; id_uses_rt = 1; id_is_muldiv = 1;
    ex_rd = 1; ex_rs = 3; ex_rt = 3; ex_mem_read = 1; ex_reg_write = 1;
    mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
    ex_branch_taken = 1;
    #1;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush got %b want 0", flush_ifid); end
    n_checks++; if (bubble_idex !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bubble got %b want 0", bubble_idex); end
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
    n_checks++; if (muldiv_start !== 1'b0 || muldiv_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_muldiv got start=%b busy=%b want 0/0", muldiv_start, muldiv_busy); end
    @(posedge clk); #1;
    n_checks++; if (stall_cycles !== '0 || flush_count !== '0) begin n_fail++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_count); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_rd = 1; ex_mem_read = 1; ex_reg_write = 1;
    id_rs = 1; id_rt = 2; id_uses_rs = 1; id_uses_rt = 1;
    #1;
    n_checks++; if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_stall got %b/%b want 1/1", stall_pc, stall_ifid); end
    n_checks++; if (bubble_idex !== 1'b1 || flush_ifid !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_bubble got bubble=%b flush=%b want 1/0", bubble_idex, flush_ifid); end
    tick();
    // EX now holds the bubble, lw sits in MEM, add still in ID.
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_rd = 1; mem_reg_write = 1;
    #1;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_release got %b want 0", stall_pc); end
    n_checks++; if (stall_cycles !== 32'd1) begin n_fail++; $display("[TB] FAIL lu_stall_count got %0d want 1", stall_cycles); end
    tick();
    // add reaches EX, lw has moved to WB.
    ex_rs = 1; ex_rt = 2; mem_rd = 0; mem_reg_write = 0; wb_rd = 1; wb_reg_write = 1;
    #1;
    n_checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_fwd got %b/%b want 10/00", fwd_a, fwd_b); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    ex_rd = 0; ex_mem_read = 1; ex_reg_write = 1; id_rs = 0; id_uses_rs = 1;
    #1;
    n_checks++; if (stall_pc !== 1'b0 || bubble_idex !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_lu got stall=%b bubble=%b want 0/0", stall_pc, bubble_idex); end
    tick();
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("[TB] FAIL zero_count got %0d want 0", stall_cycles); end
    clear_inputs();
    mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1; ex_rs = 0; ex_rt = 0;
    #1;
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("[TB] FAIL zero_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    ex_rs = 5; ex_rt = 7; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1;
    n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("[TB] FAIL fwd_mem_prio got %b want 01", fwd_a); end
    n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("[TB] FAIL fwd_b_none got %b want 00", fwd_b); end
    mem_reg_write = 0;
    #1;
    n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("[TB] FAIL fwd_wb got %b want 10", fwd_a); end
    ex_rt = 5; mem_reg_write = 1; wb_rd = 9;
    #1;
    n_checks++; if (fwd_b !== 2'b01 || fwd_a !== 2'b01) begin n_fail++; $display("[TB] FAIL fwd_b_mem got %b/%b want 01/01", fwd_a, fwd_b); end
  endtask

  task automatic test_muldiv();
    do_reset();
    id_is_muldiv = 1;
    #1;
    n_checks++; if (muldiv_start !== 1'b1 || muldiv_busy !== 1'b0 || stall_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL md_start got start=%b busy=%b stall=%b want 1/0/0", muldiv_start, muldiv_busy, stall_pc); end
    tick();
    id_is_muldiv = 0; id_reads_hilo = 1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      n_checks++; if (muldiv_busy !== 1'b1 || muldiv_start !== 1'b0 || stall_pc !== 1'b1) begin n_fail++; $display("[TB] FAIL md_busy_%0d got busy=%b start=%b stall=%b want 1/0/1", i, muldiv_busy, muldiv_start, stall_pc); end
      tick();
    end
    #1;
    n_checks++; if (muldiv_busy !== 1'b0 || stall_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL md_release got busy=%b stall=%b want 0/0", muldiv_busy, stall_pc); end
    n_checks++; if (stall_cycles !== 32'd4) begin n_fail++; $display("[TB] FAIL md_stall_count got %0d want 4", stall_cycles); end
    tick();
    id_reads_hilo = 0; id_is_muldiv = 1;
    #1;
    n_checks++; if (muldiv_start !== 1'b1) begin n_fail++; $display("[TB] FAIL md_restart got %b want 1", muldiv_start); end
    tick();
    id_is_muldiv = 1;
    #1;
    n_checks++; if (muldiv_start !== 1'b0 || stall_pc !== 1'b1) begin n_fail++; $display("[TB] FAIL md_structural got start=%b stall=%b want 0/1", muldiv_start, stall_pc); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_rd = 1; ex_mem_read = 1; ex_reg_write = 1; id_rs = 1; id_uses_rs = 1;
    id_is_muldiv = 1; ex_branch_taken = 1;
    #1;
    n_checks++; if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_nostall got %b/%b want 0/0", stall_pc, stall_ifid); end
    n_checks++; if (flush_ifid !== 1'b1 || bubble_idex !== 1'b1) begin n_fail++; $display("[TB] FAIL br_flush got flush=%b bubble=%b want 1/1", flush_ifid, bubble_idex); end
    tick();
    n_checks++; if (flush_count !== 32'd1 || stall_cycles !== 32'd0) begin n_fail++; $display("[TB] FAIL br_counters got flush=%0d stall=%0d want 1/0", flush_count, stall_cycles); end
    clear_inputs();
    id_is_muldiv = 1; ex_branch_taken = 1;
    #1;
    n_checks++; if (muldiv_start !== 1'b0) begin n_fail++; $display("[TB] FAIL br_wrong_path_md got %b want 0", muldiv_start); end
    tick();
    ex_branch_taken = 0;
    #1;
    n_checks++; if (muldiv_busy !== 1'b0 || muldiv_start !== 1'b1) begin n_fail++; $display("[TB] FAIL br_md_after got busy=%b start=%b want 0/1", muldiv_busy, muldiv_start); end
    tick();
    id_is_muldiv = 0; ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    #1;
    n_checks++; if (muldiv_busy !== 1'b1 || flush_count !== 32'd3) begin n_fail++; $display("[TB] FAIL br_busy_through got busy=%b flush=%0d want 1/3", muldiv_busy, flush_count); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    id_is_muldiv = 1;
    tick();
    id_is_muldiv = 0; id_reads_hilo = 1;
    tick();
    tick();
    n_checks++; if (stall_cycles !== 32'd2 || muldiv_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rmb_pre got stall=%0d busy=%b want 2/1", stall_cycles, muldiv_busy); end
    rst = 1'b1;
    md_left = 0; exp_stall = '0; exp_flush = '0;
    #1;
    n_checks++; if (muldiv_busy !== 1'b0 || stall_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL rmb_async got busy=%b stall=%b want 0/0", muldiv_busy, stall_pc); end
    n_checks++; if (stall_cycles !== '0 || flush_count !== '0) begin n_fail++; $display("[TB] FAIL rmb_counters got %0d/%0d want 0/0", stall_cycles, flush_count); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (stall_pc !== 1'b0 || muldiv_start !== 1'b0 || muldiv_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmb_after got stall=%b start=%b busy=%b want 0/0/0", stall_pc, muldiv_start, muldiv_busy); end
    tick();
    n_checks++; if (muldiv_busy !== 1'b0 || stall_cycles !== '0) begin n_fail++; $display("[TB] FAIL rmb_idle got busy=%b stall=%0d want 0/0", muldiv_busy, stall_cycles); end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(99) == 0);
      if (rst) begin
        md_left = 0; exp_stall = '0; exp_flush = '0;
      end
      id_rs = AW'($urandom_range(3)); id_rt = AW'($urandom_range(3));
      ex_rs = AW'($urandom_range(3)); ex_rt = AW'($urandom_range(3));
      ex_rd = AW'($urandom_range(3)); mem_rd = AW'($urandom_range(3));
      wb_rd = AW'($urandom_range(3));
      id_uses_rs = $urandom_range(1); id_uses_rt = $urandom_range(1);
      id_is_muldiv = ($urandom_range(3) == 0);
      id_reads_hilo = ($urandom_range(3) == 0);
      ex_reg_write = $urandom_range(1); ex_mem_read = $urandom_range(1);
      mem_reg_write = $urandom_range(1); wb_reg_write = $urandom_range(1);
      ex_branch_taken = ($urandom_range(6) == 0);
      #1;
      e = model_now();
      n_checks++; if (stall_pc !== e.stall || stall_ifid !== e.stall) begin n_fail++; $display("[TB] FAIL rnd_stall cyc %0d got %b/%b want %b", cyc, stall_pc, stall_ifid, e.stall); end
      n_checks++; if (flush_ifid !== e.flush || bubble_idex !== e.bubble) begin n_fail++; $display("[TB] FAIL rnd_flush cyc %0d got flush=%b bubble=%b want %b/%b", cyc, flush_ifid, bubble_idex, e.flush, e.bubble); end
      n_checks++; if (fwd_a !== e.fa || fwd_b !== e.fb) begin n_fail++; $display("[TB] FAIL rnd_fwd cyc %0d got %b/%b want %b/%b", cyc, fwd_a, fwd_b, e.fa, e.fb); end
      n_checks++; if (muldiv_start !== e.start || muldiv_busy !== e.busy) begin n_fail++; $display("[TB] FAIL rnd_md cyc %0d got start=%b busy=%b want %b/%b", cyc, muldiv_start, muldiv_busy, e.start, e.busy); end
      n_checks++; if (stall_cycles !== exp_stall || flush_count !== exp_flush) begin n_fail++; $display("[TB] FAIL rnd_counters cyc %0d got %0d/%0d want %0d/%0d", cyc, stall_cycles, flush_count, exp_stall, exp_flush); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_fwd_priority();
    test_muldiv();
    test_branch();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline. It sits beside the IF/ID/EX/MEM/WB pipeline registers inside Top.
- Generates the following:
  - PC and IF/ID hold (stall) signals.
  - ID/EX bubble insertion and IF/ID flush on taken branches.
  - EX operand forwarding selects.
- Sequences the multi-cycle MULT/DIV unit and its HI/LO interlock.
- Keeps stall/flush performance counters for bench inspection.

Parameters:
- REG_AW, 5, register address width.
- MULDIV_LAT, 4, cycles the MULT/DIV unit needs from start to HI/LO valid (legal range 2..15).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  REG_AW  rs field of instruction in ID.
- id_rt  in  REG_AW  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO.
- ex_rs  in  REG_AW  rs of instruction in EX.
- ex_rt  in  REG_AW  rt of instruction in EX.
- ex_rd  in  REG_AW  destination of instruction in EX.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  destination of instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes a register.
- wb_rd  in  REG_AW  destination of instruction in WB.
- wb_reg_write  in  1  WB instruction writes a register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- flush_ifid  out  1  zero IF/ID register (NOP).
- bubble_idex  out  1  load NOP into ID/EX.
- fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB result.
- fwd_b  out  2  EX operand B source, same encoding.
- muldiv_start  out  1  one-cycle start pulse to MULT/DIV unit.
- muldiv_busy  out  1  MULT/DIV in progress.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1.
- flush_count  out  CNT_W  count of taken-branch flushes.

Behaviour:

Reset:
- rst=1 asynchronously forces state IDLE, countdown=0, stall_cycles=0, flush_count=0.
- While rst=1, all combinational outputs are 0 regardless of inputs.

Hazard matching:
- Register 0 never creates a hazard and is never forwarded.
- `match(x,y)` = (x==y) && (y!=0).

Load-use hazard:
- `lu = ex_mem_read && ex_reg_write && ((id_uses_rs && match(id_rs,ex_rd)) || (id_uses_rt && match(id_rt,ex_rd)))`.

MULT/DIV FSM, states IDLE and BUSY:
- IDLE -> BUSY when `id_is_muldiv && !lu && !ex_branch_taken`.
  - On this transition: muldiv_start=1 (combinational, same cycle) and countdown loads MULDIV_LAT-1.
- BUSY: countdown decrements each cycle. countdown==0 -> IDLE.
  - HI/LO is valid from the first IDLE cycle onward.
- muldiv_busy = (state==BUSY).
- `md = muldiv_busy && (id_is_muldiv || id_reads_hilo)`. This is a structural/HI-LO interlock.

Outputs:
- `stall = (lu || md) && !ex_branch_taken`.
- stall_pc = stall_ifid = stall.
- bubble_idex = stall || ex_branch_taken.
- flush_ifid = ex_branch_taken.
- Taken branch has priority: the wrong-path ID instruction is flushed, not stalled, and never starts MULT/DIV.
- A MULT/DIV already in BUSY continues through a flush.

Forwarding (combinational, zero latency):
- fwd_a = 01 if `mem_reg_write && match(ex_rs,mem_rd)`, else 10 if `wb_reg_write && match(ex_rs,wb_rd)`, else 00.
- MEM has priority over WB.
- fwd_b is the same using ex_rt.

Counters:
- stall_cycles increments on every clk edge where stall=1.
- flush_count increments on every edge where ex_branch_taken=1.
- Both wrap modulo 2^CNT_W.

Simultaneous conditions:
- lu and md true together: a single stall cycle is counted once per cycle.
- md stalls until the BUSY->IDLE transition. The MFHI/MFLO then leaves ID on the first IDLE cycle.

Reset mid-operation:
- Reset during BUSY aborts the sequence. No muldiv_start is reissued until a new MULT/DIV is decoded.

Decomposition:
- Shared package `mips_pkg`:
  - fwd select localparams: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_AW.
  - MD_IDLE/MD_BUSY state encoding.
- One sub-module `muldiv_seq`: the IDLE/BUSY FSM plus countdown, producing muldiv_start and muldiv_busy.
- Hazard logic, forwarding and counters stay in the top of the block.

Test Plan:
1. Load-use: EX `lw $1` (ex_rd=1, ex_mem_read=1, ex_reg_write=1), ID `add $3,$1,$2` -> exactly 1 cycle with stall_pc=stall_ifid=bubble_idex=1; stall_cycles=1.
2. Zero register: EX `lw $0`, ID uses rs=0 -> no stall. Separately, mem_rd=0 with ex_rs=0 -> fwd_a=00.
3. Forwarding priority: ex_rs=5, mem_rd=5 and wb_rd=5 both writing -> fwd_a=01. Deassert mem_reg_write -> fwd_a=10. ex_rt=7, no matches -> fwd_b=00.
4. MULT/DIV: MULDIV_LAT=4, ID MULT -> muldiv_start pulse 1 cycle, muldiv_busy for 4 cycles. Following MFLO in ID -> stall for 4 cycles, released on the first IDLE cycle; stall_cycles=4.
5. Branch vs stall: lu=1 and ex_branch_taken=1 in the same cycle -> stall_pc=0, flush_ifid=1, bubble_idex=1; flush_count=1, stall_cycles unchanged. Wrong-path MULT in ID -> no muldiv_start.
6. Reset mid-BUSY: assert rst 2 cycles after muldiv_start -> muldiv_busy=0 immediately (asynchronous), both counters 0. After release, no stall with MFHI in ID.
